// File: rtl/set_inst_issuer.sv
// Producer side of the SET instruction interface: buffers register-load requests,
// issues encoded SET instructions through a valid/ready slot and tracks the expected register file.
module set_inst_issuer #(
    parameter int         DEPTH   = 4,
    parameter logic [1:0] SET_OPC = 2'b10,
    parameter int         CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_rd,
    input  logic [3:0]               req_imm,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [7:0]               inst,
    output logic [7:0]               shadow_r0,
    output logic [7:0]               shadow_r1,
    output logic [7:0]               shadow_r2,
    output logic [7:0]               shadow_r3,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         issue_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [5:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic [LW-1:0]    level_next;
    logic             inst_valid_reg;
    logic [7:0]       inst_reg;
    logic [CNT_W-1:0] issue_cnt_reg;

    logic push;
    logic pop;
    logic fire;

    // Acceptance depends only on stored occupancy, so a drain in the same cycle cannot open a slot.
    assign req_ready = (level_reg < LW'(DEPTH));
    assign push      = req_valid & req_ready;
    assign fire      = inst_valid_reg & inst_ready;
    assign pop       = (level_reg != '0) & (~inst_valid_reg | inst_ready);

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
    end

    // Storage has no reset; validity is carried entirely by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {req_imm, req_rd};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            level_reg <= level_next;
        end
    end

    // Output slot: refilled from the FIFO head whenever it is empty or being consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_valid_reg <= 1'b0;
            inst_reg       <= 8'h00;
        end else if (pop) begin
            inst_valid_reg <= 1'b1;
            inst_reg       <= {SET_OPC, mem[rd_ptr_reg]};
        end else if (fire) begin
            inst_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt_reg <= '0;
        end else if (fire) begin
            issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gen_shadow
            logic [7:0] shadow_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shadow_reg <= 8'h00;
                end else if (fire && (inst_reg[1:0] == 2'(gi))) begin
                    shadow_reg <= {4'd0, inst_reg[5:2]};
                end
            end
        end
    endgenerate

    assign shadow_r0  = gen_shadow[0].shadow_reg;
    assign shadow_r1  = gen_shadow[1].shadow_reg;
    assign shadow_r2  = gen_shadow[2].shadow_reg;
    assign shadow_r3  = gen_shadow[3].shadow_reg;
    assign inst_valid = inst_valid_reg;
    assign inst       = inst_reg;
    assign fifo_level = level_reg;
    assign issue_cnt  = issue_cnt_reg;

endmodule

// File: tb/tb_set_inst_issuer.sv
// Directed bench for set_inst_issuer: fill/stall, streaming, random stalls, async reset and counter wrap.
module tb_set_inst_issuer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_rd = 2'd0;
    logic [3:0]  req_imm = 4'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [7:0]  inst;
    logic [7:0]  shadow_r0, shadow_r1, shadow_r2, shadow_r3;
    logic [2:0]  fifo_level;
    logic [15:0] issue_cnt;

    logic        req_ready4, inst_valid4;
    logic [7:0]  inst4, s0_4, s1_4, s2_4, s3_4;
    logic [2:0]  fifo_level4;
    logic [3:0]  issue_cnt4;

    always #5 clk = ~clk;

    set_inst_issuer #(.DEPTH(4), .SET_OPC(2'b10), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd), .req_imm(req_imm),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .shadow_r0(shadow_r0), .shadow_r1(shadow_r1), .shadow_r2(shadow_r2), .shadow_r3(shadow_r3),
        .fifo_level(fifo_level), .issue_cnt(issue_cnt)
    );

    set_inst_issuer #(.DEPTH(4), .SET_OPC(2'b10), .CNT_W(4)) u_dut_cnt4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready4), .req_rd(req_rd), .req_imm(req_imm),
        .inst_valid(inst_valid4), .inst_ready(inst_ready), .inst(inst4),
        .shadow_r0(s0_4), .shadow_r1(s1_4), .shadow_r2(s2_4), .shadow_r3(s3_4),
        .fifo_level(fifo_level4), .issue_cnt(issue_cnt4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] enc(input logic [1:0] rd, input logic [3:0] imm);
        return {2'b10, imm, rd};
    endfunction

    // Scoreboard: accepted requests in order, checked against every issue handshake.
    logic [7:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_inst  = 8'h00;
    int         run_len    = 0;
    int         max_run    = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
            run_len    = 0;
        end else begin
            if (prev_stall) begin
                check_val("stall_valid", {31'd0, inst_valid}, 32'd1);
                check_val("stall_inst", {24'd0, inst}, {24'd0, prev_inst});
            end
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("issue_unexpected", {24'd0, inst}, 32'h100);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check_val("issue_order", {24'd0, inst}, {24'd0, e});
                    $display("issue inst=0x%02h expected=0x%02h", inst, e);
                end
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (req_valid && req_ready) exp_q.push_back(enc(req_rd, req_imm));
            prev_stall = inst_valid && !inst_ready;
            prev_inst  = inst;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        inst_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd);
        int k;
        k = 0;
        while ((inst_valid || fifo_level != 3'd0) && k < 1000) begin
            if (rnd) inst_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        check_val("idle_bound", {31'd0, (k < 1000)}, 32'd1);
        inst_ready = 1'b1;
    endtask

    task automatic push_req(input logic [1:0] rd, input logic [3:0] imm);
        req_valid = 1'b1;
        req_rd    = rd;
        req_imm   = imm;
        tick();
    endtask

    initial begin
        do_reset();
        // Reset state
        check_val("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_val("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check_val("rst_inst", {24'd0, inst}, 32'h00);
        check_val("rst_level", {29'd0, fifo_level}, 32'd0);
        check_val("rst_cnt", {16'd0, issue_cnt}, 32'd0);
        check_val("rst_shadow", {shadow_r3, shadow_r2, shadow_r1, shadow_r0}, 32'h0);

        // Single request: two-cycle latency, then handshake updates r2
        inst_ready = 1'b1;
        push_req(2'd2, 4'hB);
        req_valid = 1'b0;
        check_val("lat_c1_valid", {31'd0, inst_valid}, 32'd0);
        check_val("lat_c1_level", {29'd0, fifo_level}, 32'd1);
        tick();
        check_val("lat_c2_valid", {31'd0, inst_valid}, 32'd1);
        check_val("lat_c2_inst", {24'd0, inst}, 32'hAE);
        tick();
        check_val("single_shadow", {shadow_r3, shadow_r2, shadow_r1, shadow_r0}, 32'h000B0000);
        check_val("single_cnt", {16'd0, issue_cnt}, 32'd1);
        check_val("single_drained", {31'd0, inst_valid}, 32'd0);

        // Fill with the consumer stalled: 4 in FIFO plus one in the slot
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_val("fill_ready", {31'd0, req_ready}, 32'd1);
            push_req(2'(i % 4), 4'(i + 1));
        end
        check_val("full_ready", {31'd0, req_ready}, 32'd0);
        check_val("full_level", {29'd0, fifo_level}, 32'd4);
        check_val("full_inst", {24'd0, inst}, 32'h84);
        push_req(2'd3, 4'hF);
        tick();
        check_val("full_hold_level", {29'd0, fifo_level}, 32'd4);
        // Draining the slot does not open the full FIFO in the same cycle
        inst_ready = 1'b1;
        check_val("full_drain_ready", {31'd0, req_ready}, 32'd0);
        tick();
        req_valid = 1'b0;
        check_val("full_drain_level", {29'd0, fifo_level}, 32'd3);
        wait_idle(1'b0);
        check_val("fill_shadow", {shadow_r3, shadow_r2, shadow_r1, shadow_r0}, 32'h04030205);
        check_val("fill_cnt", {16'd0, issue_cnt}, 32'd6);

        // Streaming at full rate
        max_run = 0;
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_req(2'(i % 4), 4'(i + 1));
        req_valid = 1'b0;
        wait_idle(1'b0);
        check_val("stream_shadow", {shadow_r3, shadow_r2, shadow_r1, shadow_r0}, 32'h08070605);
        check_val("stream_run", max_run, 32'd8);
        check_val("stream_cnt", {16'd0, issue_cnt}, 32'd14);

        // 100 requests under random consumer stalls
        do_reset();
        begin
            int n;
            int cyc;
            bit acc;
            n = 0;
            cyc = 0;
            while (n < 100 && cyc < 5000) begin
                req_valid  = 1'b1;
                req_rd     = 2'($urandom_range(0, 3));
                req_imm    = 4'($urandom_range(0, 15));
                inst_ready = 1'($urandom_range(0, 1));
                acc = req_ready;
                tick();
                if (acc) n++;
                cyc++;
            end
            req_valid = 1'b0;
            check_val("rand_push_bound", n, 32'd100);
        end
        wait_idle(1'b1);
        check_val("rand_cnt", {16'd0, issue_cnt}, 32'd100);
        check_val("rand_q_empty", exp_q.size(), 32'd0);

        // Asynchronous reset with 3 buffered entries and a pending instruction
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_req(2'(i % 4), 4'(i + 9));
        req_valid = 1'b0;
        check_val("pre_rst_level", {29'd0, fifo_level}, 32'd3);
        check_val("pre_rst_valid", {31'd0, inst_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("arst_req_ready", {31'd0, req_ready}, 32'd1);
        check_val("arst_valid", {31'd0, inst_valid}, 32'd0);
        check_val("arst_inst", {24'd0, inst}, 32'h00);
        check_val("arst_level", {29'd0, fifo_level}, 32'd0);
        check_val("arst_cnt", {16'd0, issue_cnt}, 32'd0);
        check_val("arst_shadow", {shadow_r3, shadow_r2, shadow_r1, shadow_r0}, 32'h0);
        tick();
        rst = 1'b0;
        inst_ready = 1'b1;
        push_req(2'd1, 4'h3);
        req_valid = 1'b0;
        tick();
        check_val("post_rst_inst", {24'd0, inst}, 32'h8D);
        tick();
        check_val("post_rst_shadow", {shadow_r3, shadow_r2, shadow_r1, shadow_r0}, 32'h00000300);
        check_val("post_rst_cnt", {16'd0, issue_cnt}, 32'd1);

        // Counter wrap on the narrow-counter instance
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 17; i++) push_req(2'(i % 4), 4'(i));
        req_valid = 1'b0;
        wait_idle(1'b0);
        check_val("wrap_cnt16", {16'd0, issue_cnt}, 32'd17);
        check_val("wrap_cnt4", {28'd0, issue_cnt4}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
